// File: rtl/tiny_host_bridge_if.sv
// tiny_host_bridge_if
// Host-side access channel of the bridge: a request/ready handshake for
// single-word RAM reads and writes, plus the read-return strobe and data.
//   req, w, addr, wdata : request, write flag, word address, write data (host -> bridge)
//   ready               : request accepted this cycle when req && ready (bridge -> host)
//   rvalid, rdata       : read data strobe and data, one cycle after an accepted read
interface tiny_host_bridge_if #(
  parameter int DW = 198,
  parameter int AW = 7
) ();
  logic          req;
  logic          w;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, w, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input req, w, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/tiny_host_bridge.sv
// tiny_host_bridge
// Shares RAM port A between a host and a compute engine. While idle (or
// finished) the host owns the port; a start request resets the engine for one
// cycle, then hands the port to the engine until it reports completion or an
// optional cycle limit expires.
//
// state  | meaning
// IDLE   | host owns port A, engine held in reset
// LAUNCH | one-cycle engine reset pulse, clears status, loads timeout counter
// RUN    | engine owns port A, counter running
// FINISH | host owns port A, done/err hold the outcome of the last run
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   host                  : host access channel (slave side)
//   start, timeout        : run launch, run cycle limit (0 = unlimited)
//   busy, done, err       : run status
//   core_reset, core_addr, core_done : engine reset, engine address, engine completion
//   ram_addr, ram_w, ram_wdata, ram_rdata : RAM port A (1-cycle synchronous read)
module tiny_host_bridge #(
  parameter int DW = 198,
  parameter int AW = 7,
  parameter int TW = 20
) (
  input  logic          clk,
  input  logic          reset,
  tiny_host_bridge_if.slave host,
  input  logic          start,
  input  logic [TW-1:0] timeout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          core_reset,
  input  logic [AW-1:0] core_addr,
  input  logic          core_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_w,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q;
  logic          rvalid_q;
  logic          host_side;
  logic          expire;

  // A zero count never decrements, so a run launched with timeout=0 can only
  // end on core_done.
  assign expire = (cnt_q == TW'(1));

  always_comb begin
    state_d    = state_q;
    host_side  = 1'b0;
    busy       = 1'b0;
    core_reset = 1'b0;
    case (state_q)
      IDLE: begin
        host_side  = 1'b1;
        core_reset = 1'b1;
        if (start) state_d = LAUNCH;
      end
      FINISH: begin
        host_side = 1'b1;
        if (start) state_d = LAUNCH;
      end
      LAUNCH: begin
        busy       = 1'b1;
        core_reset = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (core_done || expire) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr     = host_side ? host.addr : core_addr;
  assign ram_w        = host_side && host.req && host.w;
  assign ram_wdata    = host.wdata;
  assign host.ready   = host_side;
  assign host.rvalid  = rvalid_q;
  assign host.rdata   = ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      // A read accepted in the cycle that also starts a run still returns
      // its data during LAUNCH, since this tracks acceptance only.
      rvalid_q <= host_side && host.req && !host.w;

      if (state_q == LAUNCH)
        cnt_q <= timeout;
      else if (state_q == RUN && cnt_q != '0)
        cnt_q <= cnt_q - TW'(1);

      // Status is cleared on entry to LAUNCH so it reads 0 throughout the run.
      if (host_side && start) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else if (state_q == RUN && (core_done || expire)) begin
        done <= 1'b1;
        err  <= !core_done;   // completion in the expiry cycle counts as success
      end
    end
  end

endmodule
